// File: rtl/led_matrix_scanner.sv
// Multiplexed scanner for NUM_DISP matrices of ROWS x COLS LEDs, fed by a double-buffered framebuffer.
// Optional per-column dimming is enabled by defining LED_SCANNER_DIM_EN.
module led_matrix_scanner #(
   parameter int unsigned NUM_DISP   = 2,
   parameter int unsigned ROWS       = 8,
   parameter int unsigned COLS       = 8,
   parameter int unsigned DWELL_LOG2 = 14
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_valid,
   input  logic [ROWS-1:0]          load_data,
   output logic                     load_ready,
   input  logic                     load_clear,
`ifdef LED_SCANNER_DIM_EN
   input  logic [3:0]               brightness,
`endif
   output logic [ROWS-1:0]          row,
   output logic [NUM_DISP*COLS-1:0] col,
   output logic [NUM_DISP-1:0]      disp_sel,
   output logic                     frame_pending,
   output logic                     frame_done
);

   localparam int unsigned NUM_WORDS = NUM_DISP * COLS;
   localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned DISP_W    = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
   localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [0:0] {StScan, StSwap} state_e;

   state_e                  state_q;
   logic [ROWS-1:0]         front_q [NUM_WORDS];
   logic [ROWS-1:0]         back_q  [NUM_WORDS];
   logic [IDX_W-1:0]        widx_q;
   logic                    pending_q;
   logic                    ready_q;
   logic [DISP_W-1:0]       disp_q;
   logic [COL_W-1:0]        colidx_q;
   logic [DWELL_LOG2-1:0]   dwell_q;
   logic [ROWS-1:0]         row_q;
   logic [NUM_WORDS-1:0]    col_q;
   logic [NUM_DISP-1:0]     disp_sel_q;
   logic                    done_q;

   logic                    handshake;
   logic                    last_word;
   logic                    pending_d;
   logic                    dwell_end;
   logic                    col_last;
   logic                    disp_last;
   logic                    lit;
   logic [IDX_W-1:0]        scan_idx;
   logic [NUM_WORDS-1:0]    col_onehot;
   logic [NUM_DISP-1:0]     disp_onehot;

`ifdef LED_SCANNER_DIM_EN
   logic [3:0]              bright_q;
   assign lit = (dwell_q[DWELL_LOG2-1 -: 4] <= bright_q);
`else
   assign lit = 1'b1;
`endif

   // load_clear wins over a same-cycle handshake, so that word is dropped
   assign handshake   = load_valid && ready_q && !load_clear;
   assign last_word   = (widx_q == IDX_W'(NUM_WORDS - 1));
   assign dwell_end   = &dwell_q;
   assign col_last    = (colidx_q == COL_W'(COLS - 1));
   assign disp_last   = (disp_q == DISP_W'(NUM_DISP - 1));
   assign scan_idx    = IDX_W'(int'(disp_q) * int'(COLS) + int'(colidx_q));
   assign col_onehot  = NUM_WORDS'(1) << scan_idx;
   assign disp_onehot = NUM_DISP'(1) << disp_q;

   always_comb begin
      pending_d = pending_q;
      if (state_q == StSwap) begin
         pending_d = 1'b0;
      end else if (handshake && last_word) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StScan;
         for (int i = 0; i < int'(NUM_WORDS); i++) begin
            front_q[i] <= '0;
            back_q[i]  <= '0;
         end
         widx_q     <= '0;
         pending_q  <= 1'b0;
         ready_q    <= 1'b0;
         disp_q     <= '0;
         colidx_q   <= '0;
         dwell_q    <= '0;
         row_q      <= '0;
         col_q      <= '0;
         disp_sel_q <= '0;
         done_q     <= 1'b0;
`ifdef LED_SCANNER_DIM_EN
         bright_q   <= brightness;
`endif
      end else begin
         pending_q <= pending_d;
         // Ready drops on the same edge the frame completes, so nothing can overwrite it
         ready_q   <= !pending_d;

         if (load_clear) begin
            widx_q <= '0;
         end else if (handshake) begin
            back_q[widx_q] <= load_data;
            widx_q         <= last_word ? '0 : widx_q + 1'b1;
         end

         case (state_q)
            StScan: begin
               row_q      <= lit ? front_q[scan_idx] : '0;
               col_q      <= lit ? col_onehot : '0;
               disp_sel_q <= disp_onehot;
               done_q     <= 1'b0;
               dwell_q    <= dwell_q + 1'b1;
               if (dwell_end) begin
`ifdef LED_SCANNER_DIM_EN
                  bright_q <= brightness;
`endif
                  if (col_last) begin
                     colidx_q <= '0;
                     if (disp_last) begin
                        disp_q <= '0;
                        if (pending_q) begin
                           state_q <= StSwap;
                        end
                     end else begin
                        disp_q <= disp_q + 1'b1;
                     end
                  end else begin
                     colidx_q <= colidx_q + 1'b1;
                  end
               end
            end
            StSwap: begin
               for (int i = 0; i < int'(NUM_WORDS); i++) begin
                  front_q[i] <= back_q[i];
               end
               row_q      <= '0;
               col_q      <= '0;
               disp_sel_q <= '0;
               done_q     <= 1'b1;
               dwell_q    <= '0;
               disp_q     <= '0;
               colidx_q   <= '0;
               state_q    <= StScan;
            end
            default: state_q <= StScan;
         endcase
      end
   end

   assign load_ready    = ready_q;
   assign frame_pending = pending_q;
   assign frame_done    = done_q;
   assign row           = row_q;
   assign col           = col_q;
   assign disp_sel      = disp_sel_q;

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised successor to the fixed two-display 8x8 LED multiplexer.
- Scans NUM_DISP matrices of ROWS x COLS LEDs, one column at a time, with a programmable dwell per column.
- Image comes from a double-buffered framebuffer loaded over a valid/ready column-word stream; the upstream SPI deserialiser drives that stream.
- A new frame is swapped in only at a full-scan boundary, so the display never tears.

Parameters:
NUM_DISP, 2, number of LED matrices scanned in turn
ROWS, 8, rows per matrix; width of one column word
COLS, 8, columns per matrix
DWELL_LOG2, 14, each column lit for 2**DWELL_LOG2 clk cycles; must be >= 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
load_valid  in  1  column word on load_data is valid
load_data  in  ROWS  row pattern for one column; bit r drives row[r]
load_ready  out  1  back buffer can accept a word
load_clear  in  1  discard the partially written back frame; restart at word 0
row  out  ROWS  row drive for the active column
col  out  NUM_DISP*COLS  one-hot column drive; slice d*COLS +: COLS belongs to display d
disp_sel  out  NUM_DISP  one-hot active display
frame_pending  out  1  complete back frame waiting for swap
frame_done  out  1  one-cycle pulse on the cycle the swap occurs

Behaviour:
- Storage: front and back buffers, each NUM_DISP*COLS words of ROWS bits. Word index i = d*COLS + c.
- Reset (reset==0 at posedge clk):
  - Both buffers cleared to 0; write index = 0; frame_pending = 0.
  - Scan position = display 0, column 0; dwell counter = 0.
  - Registered outputs: row=0, col=0, disp_sel=0, frame_done=0, load_ready=0.
  - Reset mid-load or mid-scan discards everything.
- Load path:
  - load_ready = !frame_pending (registered; 1 from the first cycle after reset release).
  - Handshake (load_valid && load_ready) writes load_data to back[write index], then write index += 1.
  - Writing index NUM_DISP*COLS-1 wraps the index to 0 and sets frame_pending=1; load_ready falls the next cycle.
  - load_valid while load_ready=0 is ignored; no data is lost or overwritten.
  - load_clear=1 sets write index to 0 and takes priority over a same-cycle handshake; that word is dropped.
  - load_clear does not clear frame_pending.
- Scan FSM, states SCAN and SWAP:
  - SCAN: dwell counter increments every cycle. On wrap (all ones -> 0), column advances.
  - Column COLS-1 advances to column 0 of the next display. Display NUM_DISP-1 wraps to display 0; that is the end of scan.
  - End of scan with frame_pending=1 -> SWAP.
  - SWAP lasts exactly one cycle: front <= back, frame_pending <= 0, frame_done=1, outputs blanked (row=0, col=0, disp_sel=0), dwell counter held at 0. Returns to SCAN at display 0, column 0.
  - A handshake on the same cycle frame_pending is cleared is impossible, because load_ready is still 0.
- Outputs are registered, one cycle after scan state:
  - row = front[current index].
  - col has only bit (d*COLS+c) set.
  - disp_sel has only bit d set.
- Full-scan period: NUM_DISP*COLS*2**DWELL_LOG2 cycles, plus 1 cycle if a swap occurs.

Optional Feature:
- Macro: LED_SCANNER_DIM_EN.
- Defined:
  - Adds input port brightness [3:0].
  - col and row are forced to 0 whenever the top four dwell-counter bits are > brightness.
  - Duty per column is (brightness+1)/16: 15 = always lit, 0 = 1/16.
  - brightness is sampled at every column advance, so it never changes mid-dwell.
- Not defined: no brightness port; outputs are lit for the whole dwell.

Test Plan:
All scenarios use NUM_DISP=2, ROWS=8, COLS=8, DWELL_LOG2=4 (16 cycles per column; 256-cycle scan).
- Reset hold 3 cycles, then release -> next cycle row=0, col=16'h0001, disp_sel=2'b01, load_ready=1; col=16'h0002 exactly 16 cycles later.
- Stream 16 words 8'h01..8'h10 back-to-back -> frame_pending=1 after word 16, load_ready=0. At next end of scan, frame_done pulses once with all outputs 0. Then disp 0 col 0 shows row=8'h01, and disp 1 col 7 shows row=8'h10.
- Hold load_valid=1 with 8'hFF while frame_pending=1 -> no write occurs; frame after swap matches the committed data.
- Write 5 words, assert load_clear together with a valid word, then write 16 words of 8'hA5 -> swapped frame is all 8'hA5; the dropped word never appears.
- Assert reset mid-scan after 3 loaded words -> outputs 0 and frame_pending=0. A subsequent 16-word load commits correctly starting at index 0.
- LED_SCANNER_DIM_EN with brightness=4'd3, front all 8'hFF -> per column, row=8'hFF for dwell counts 0..3 and 0 for counts 4..15. brightness=15 -> lit all 16 cycles.
